// File: rtl/simd_pkg.sv
// Shared types for the parametrised SIMD vector core: instruction opcodes,
// lane operations and the control FSM state encoding.
package simd_pkg;

    localparam int unsigned DEF_LANES  = 4;
    localparam int unsigned DEF_LANE_W = 32;
    localparam int unsigned DEF_ADDR_W = 16;

    typedef enum logic [1:0] {
        INSTR_LD   = 2'd0,
        INSTR_INFO = 2'd1
    } instr_op_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_MUL = 2'd1,
        OP_SUB = 2'd2,
        OP_XOR = 2'd3
    } simd_op_t;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_LD_A     = 4'd1,
        ST_LD_B     = 4'd2,
        ST_LD_D     = 4'd3,
        ST_SET_INFO = 4'd4,
        ST_FETCH_A  = 4'd5,
        ST_FETCH_B  = 4'd6,
        ST_EXEC     = 4'd7,
        ST_WRITE    = 4'd8,
        ST_FINISHED = 4'd9
    } state_t;

endpackage

// File: rtl/simd_lane_alu.sv
// One combinational SIMD lane: (a, b, op) -> res.
// SIMD_VEC_SAT_EN selects signed-saturating ADD/SUB; otherwise all ops wrap.
module simd_lane_alu
    import simd_pkg::*;
#(
    parameter int unsigned LANE_W = 32
) (
    input  logic [LANE_W-1:0] a_i,
    input  logic [LANE_W-1:0] b_i,
    input  logic [1:0]        op_i,
    output logic [LANE_W-1:0] res_o
);

    logic [LANE_W-1:0] sum;
    logic [LANE_W-1:0] diff;
    logic [LANE_W-1:0] add_res;
    logic [LANE_W-1:0] sub_res;

    assign sum  = a_i + b_i;
    assign diff = a_i - b_i;

`ifdef SIMD_VEC_SAT_EN
    localparam logic [LANE_W-1:0] S_MAX = {1'b0, {(LANE_W-1){1'b1}}};
    localparam logic [LANE_W-1:0] S_MIN = {1'b1, {(LANE_W-1){1'b0}}};

    logic              add_ovf;
    logic              sub_ovf;
    logic [LANE_W-1:0] clamp;

    // Overflow always lands on the side of a's sign, so one clamp value serves both.
    assign add_ovf = (a_i[LANE_W-1] == b_i[LANE_W-1]) && (sum[LANE_W-1]  != a_i[LANE_W-1]);
    assign sub_ovf = (a_i[LANE_W-1] != b_i[LANE_W-1]) && (diff[LANE_W-1] != a_i[LANE_W-1]);
    assign clamp   = a_i[LANE_W-1] ? S_MIN : S_MAX;
    assign add_res = add_ovf ? clamp : sum;
    assign sub_res = sub_ovf ? clamp : diff;
`else
    assign add_res = sum;
    assign sub_res = diff;
`endif

    always_comb begin
        res_o = '0;
        case (simd_op_t'(op_i))
            OP_ADD:  res_o = add_res;
            OP_MUL:  res_o = a_i * b_i;
            OP_SUB:  res_o = sub_res;
            OP_XOR:  res_o = a_i ^ b_i;
            default: res_o = '0;
        endcase
    end

endmodule

// File: rtl/simd_vec_core.sv
// Vector SIMD execution core: takes a 4-word setup stream, then loops fetch A/B,
// lane-wise execute, write D over COUNT words. Optional SIMD_VEC_SAT_EN saturates ADD/SUB.
module simd_vec_core
    import simd_pkg::*;
#(
    parameter int unsigned LANES  = DEF_LANES,
    parameter int unsigned LANE_W = DEF_LANE_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_en,
    input  logic                    i_valid,
    input  logic [1:0]              i_instr_op,
    input  logic [ADDR_W-1:0]       i_instr_info,
    output logic                    o_ack,
    output logic                    o_req,
    output logic                    o_we,
    output logic [ADDR_W-1:0]       o_addr,
    output logic [LANES*LANE_W-1:0] o_wdata,
    input  logic                    i_grant,
    input  logic [LANES*LANE_W-1:0] i_rdata,
    output logic                    o_busy,
    output logic                    o_finish
);

    localparam int unsigned VEC_W = LANES * LANE_W;
    localparam int unsigned CNT_W = ADDR_W - 2;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] a_q, a_d, b_q, b_d, d_q, d_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, idx_q, idx_d;
    simd_op_t          op_q, op_d;
    logic [VEC_W-1:0]  buf_a_q, buf_a_d, buf_b_q, buf_b_d, res_q, res_d;
    logic [VEC_W-1:0]  alu_res;

    logic              ack_q, ack_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [VEC_W-1:0]  wdata_q, wdata_d;
    logic              busy_q, busy_d;
    logic              finish_q, finish_d;

    instr_op_t         instr_op;
    logic [CNT_W-1:0]  info_cnt;
    logic              ld_ok;
    logic              info_ok;
    logic              accept;
    logic              xfer;
    logic              last;

    assign instr_op = instr_op_t'(i_instr_op);
    assign info_cnt = i_instr_info[ADDR_W-1:2];
    assign ld_ok    = i_valid && (instr_op == INSTR_LD);
    assign info_ok  = i_valid && (instr_op == INSTR_INFO);
    assign accept   = ((state_q == ST_LD_A || state_q == ST_LD_B || state_q == ST_LD_D) && ld_ok)
                   || ((state_q == ST_SET_INFO) && info_ok);
    assign xfer     = req_q && i_grant;
    assign last     = (idx_q == (cnt_q - CNT_W'(1)));

    // Lane-wise execution units.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        simd_lane_alu #(
            .LANE_W (LANE_W)
        ) u_alu (
            .a_i   (buf_a_q[l*LANE_W +: LANE_W]),
            .b_i   (buf_b_q[l*LANE_W +: LANE_W]),
            .op_i  (op_q),
            .res_o (alu_res[l*LANE_W +: LANE_W])
        );
    end

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (i_en)    state_d = ST_LD_A;
            ST_LD_A:     if (ld_ok)   state_d = ST_LD_B;
            ST_LD_B:     if (ld_ok)   state_d = ST_LD_D;
            ST_LD_D:     if (ld_ok)   state_d = ST_SET_INFO;
            ST_SET_INFO: if (info_ok) state_d = (info_cnt == '0) ? ST_FINISHED : ST_FETCH_A;
            ST_FETCH_A:  if (xfer)    state_d = ST_FETCH_B;
            ST_FETCH_B:  if (xfer)    state_d = ST_EXEC;
            ST_EXEC:                  state_d = ST_WRITE;
            ST_WRITE:    if (xfer)    state_d = last ? ST_FINISHED : ST_FETCH_A;
            ST_FINISHED: if (!i_en)   state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: setup fields, loop index, operand buffers, result.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        idx_d   = idx_q;
        buf_a_d = buf_a_q;
        buf_b_d = buf_b_q;
        res_d   = res_q;
        case (state_q)
            ST_LD_A: if (ld_ok) a_d = i_instr_info;
            ST_LD_B: if (ld_ok) b_d = i_instr_info;
            ST_LD_D: if (ld_ok) d_d = i_instr_info;
            ST_SET_INFO: begin
                if (info_ok) begin
                    cnt_d = info_cnt;
                    op_d  = simd_op_t'(i_instr_info[1:0]);
                    idx_d = '0;
                end
            end
            ST_FETCH_A: if (xfer) buf_a_d = i_rdata;
            ST_FETCH_B: if (xfer) buf_b_d = i_rdata;
            ST_EXEC:    res_d = alu_res;
            ST_WRITE:   if (xfer && !last) idx_d = idx_q + CNT_W'(1);
            default: ;
        endcase
    end

    // Output logic, computed from the upcoming state so every port is a flop.
    always_comb begin
        ack_d    = accept;
        req_d    = (state_d == ST_FETCH_A) || (state_d == ST_FETCH_B) || (state_d == ST_WRITE);
        we_d     = (state_d == ST_WRITE);
        busy_d   = (state_d != ST_IDLE);
        finish_d = (state_d == ST_FINISHED);
        addr_d   = '0;
        wdata_d  = '0;
        case (state_d)
            ST_FETCH_A: addr_d = a_q + ADDR_W'(idx_d);
            ST_FETCH_B: addr_d = b_q + ADDR_W'(idx_d);
            ST_WRITE: begin
                addr_d  = d_q + ADDR_W'(idx_d);
                wdata_d = res_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            a_q      <= '0;
            b_q      <= '0;
            d_q      <= '0;
            cnt_q    <= '0;
            op_q     <= OP_ADD;
            idx_q    <= '0;
            buf_a_q  <= '0;
            buf_b_q  <= '0;
            res_q    <= '0;
            ack_q    <= 1'b0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            busy_q   <= 1'b0;
            finish_q <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            d_q      <= d_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            idx_q    <= idx_d;
            buf_a_q  <= buf_a_d;
            buf_b_q  <= buf_b_d;
            res_q    <= res_d;
            ack_q    <= ack_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            busy_q   <= busy_d;
            finish_q <= finish_d;
        end
    end

    assign o_ack    = ack_q;
    assign o_req    = req_q;
    assign o_we     = we_q;
    assign o_addr   = addr_q;
    assign o_wdata  = wdata_q;
    assign o_busy   = busy_q;
    assign o_finish = finish_q;

endmodule

// File: tb/tb_simd_vec_core.sv
// Directed bench for simd_vec_core: vector table of single-word commands plus
// hand-written sequences for multi-cycle behaviour, against a flat memory model.
module tb_simd_vec_core;
    import simd_pkg::*;

    localparam int unsigned LANES  = 4;
    localparam int unsigned LANE_W = 32;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned VEC_W  = LANES * LANE_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              valid;
    logic [1:0]        instr_op;
    logic [ADDR_W-1:0] instr_info;
    logic              ack;
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [VEC_W-1:0]  wdata;
    logic              grant;
    logic [VEC_W-1:0]  rdata;
    logic              busy;
    logic              finish;

    logic [VEC_W-1:0] mem  [0:(1<<ADDR_W)-1];
    logic [VEC_W-1:0] wmem [0:(1<<ADDR_W)-1];

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        string            name;
        logic [VEC_W-1:0] a;
        logic [VEC_W-1:0] b;
        logic [1:0]       op;
        logic [VEC_W-1:0] exp;
    } vec_t;

    vec_t tbl [6];

    always #5 clk = ~clk;

    assign rdata = mem[addr];

    always @(posedge clk) begin
        if (req && we && grant) wmem[addr] <= wdata;
    end

    simd_vec_core #(
        .LANES  (LANES),
        .LANE_W (LANE_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_en         (en),
        .i_valid      (valid),
        .i_instr_op   (instr_op),
        .i_instr_info (instr_info),
        .o_ack        (ack),
        .o_req        (req),
        .o_we         (we),
        .o_addr       (addr),
        .o_wdata      (wdata),
        .i_grant      (grant),
        .i_rdata      (rdata),
        .o_busy       (busy),
        .o_finish     (finish)
    );

    task automatic check(input string name, input logic [VEC_W-1:0] act, input logic [VEC_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        en = 1'b0;
        valid = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Present one setup word for a cycle; the ack must show in the following cycle.
    task automatic send_word(input string name, input logic [1:0] op, input logic [ADDR_W-1:0] info);
        valid = 1'b1;
        instr_op = op;
        instr_info = info;
        tick();
        valid = 1'b0;
        check({name, " ack"}, VEC_W'(ack), VEC_W'(1));
    endtask

    task automatic wait_finish(input string name, output int n);
        n = 0;
        while (!finish && n < 200) begin
            tick();
            n++;
        end
        if (!finish) check({name, " finish timeout"}, VEC_W'(finish), VEC_W'(1));
    endtask

    task automatic setup(input string name, input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b,
                         input logic [ADDR_W-1:0] d, input int cnt, input logic [1:0] op);
        en = 1'b1;
        tick();
        send_word({name, " ldA"}, INSTR_LD, a);
        send_word({name, " ldB"}, INSTR_LD, b);
        send_word({name, " ldD"}, INSTR_LD, d);
        send_word({name, " info"}, INSTR_INFO, {14'(cnt), op});
    endtask

    task automatic close_cmd(input string name);
        en = 1'b0;
        tick();
        check({name, " idle busy"}, VEC_W'(busy), VEC_W'(0));
    endtask

    initial begin
        int n;
        logic [VEC_W-1:0] buf_a0;

        rst = 1'b1;
        en = 1'b0;
        valid = 1'b0;
        instr_op = 2'd0;
        instr_info = '0;
        grant = 1'b1;

        tbl[0] = '{"add", {32'd4, 32'd3, 32'd2, 32'd1}, {32'd40, 32'd30, 32'd20, 32'd10},
                   2'd0, {32'd44, 32'd33, 32'd22, 32'd11}};
        tbl[1] = '{"mul", {32'hFFFFFFFF, 32'h00010000, 32'd7, 32'd3}, {32'd2, 32'h00010000, 32'd6, 32'd5},
                   2'd1, {32'hFFFFFFFE, 32'd0, 32'd42, 32'd15}};
        tbl[2] = '{"sub", {32'd5, 32'd100, 32'd0, 32'd10}, {32'd6, 32'd1, 32'd1, 32'd3},
                   2'd2, {32'hFFFFFFFF, 32'd99, 32'hFFFFFFFF, 32'd7}};
        tbl[3] = '{"xor", {32'hFFFF0000, 32'hAAAAAAAA, 32'h12345678, 32'h00000000},
                   {32'h0000FFFF, 32'h55555555, 32'h12345678, 32'hDEADBEEF},
                   2'd3, {32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'hDEADBEEF}};
`ifdef SIMD_VEC_SAT_EN
        tbl[4] = '{"add_ovf", {32'h80000000, 32'hFFFFFFFF, 32'd1, 32'h7FFFFFFF}, {32'h80000000, 32'd1, 32'd1, 32'd1},
                   2'd0, {32'h80000000, 32'd0, 32'd2, 32'h7FFFFFFF}};
        tbl[5] = '{"sub_ovf", {32'h7FFFFFFF, 32'd0, 32'd3, 32'h80000000}, {32'hFFFFFFFF, 32'h80000000, 32'd3, 32'd1},
                   2'd2, {32'h7FFFFFFF, 32'h7FFFFFFF, 32'd0, 32'h80000000}};
`else
        tbl[4] = '{"add_ovf", {32'h80000000, 32'hFFFFFFFF, 32'd1, 32'h7FFFFFFF}, {32'h80000000, 32'd1, 32'd1, 32'd1},
                   2'd0, {32'h00000000, 32'd0, 32'd2, 32'h80000000}};
        tbl[5] = '{"sub_ovf", {32'h7FFFFFFF, 32'd0, 32'd3, 32'h80000000}, {32'hFFFFFFFF, 32'h80000000, 32'd3, 32'd1},
                   2'd2, {32'h80000000, 32'h80000000, 32'd0, 32'h7FFFFFFF}};
`endif

        mem[16'h0010] = {32'd4, 32'd3, 32'd2, 32'd1};
        mem[16'h0011] = {32'd8, 32'd7, 32'd6, 32'd5};
        mem[16'h0020] = {32'd40, 32'd30, 32'd20, 32'd10};
        mem[16'h0021] = {32'd80, 32'd70, 32'd60, 32'd50};
        for (int i = 0; i < 6; i++) begin
            mem[16'h0040 + 16'(i)] = tbl[i].a;
            mem[16'h0050 + 16'(i)] = tbl[i].b;
        end

        do_reset();
        check("rst req",    VEC_W'(req),    VEC_W'(0));
        check("rst busy",   VEC_W'(busy),   VEC_W'(0));
        check("rst finish", VEC_W'(finish), VEC_W'(0));
        check("rst ack",    VEC_W'(ack),    VEC_W'(0));
        check("rst addr",   VEC_W'(addr),   VEC_W'(0));
        check("rst wdata",  wdata,          VEC_W'(0));

        // Two-word ADD command, grant tied high.
        setup("cmd2", 16'h0010, 16'h0020, 16'h0030, 2, 2'd0);
        check("cmd2 first req",  VEC_W'(req),  VEC_W'(1));
        check("cmd2 first we",   VEC_W'(we),   VEC_W'(0));
        check("cmd2 first addr", VEC_W'(addr), VEC_W'(16'h0010));
        wait_finish("cmd2", n);
        check("cmd2 latency", VEC_W'(n), VEC_W'(8));
        check("cmd2 mem30", wmem[16'h0030], {32'd44, 32'd33, 32'd22, 32'd11});
        check("cmd2 mem31", wmem[16'h0031], {32'd88, 32'd77, 32'd66, 32'd55});
        tick();
        check("cmd2 hold finish", VEC_W'(finish), VEC_W'(1));
        close_cmd("cmd2");

        // Single-word commands from the vector table.
        for (int i = 0; i < 6; i++) begin
            setup(tbl[i].name, 16'h0040 + 16'(i), 16'h0050 + 16'(i), 16'h0060 + 16'(i), 1, tbl[i].op);
            wait_finish(tbl[i].name, n);
            check({tbl[i].name, " latency"}, VEC_W'(n), VEC_W'(4));
            check({tbl[i].name, " result"}, wmem[16'h0060 + 16'(i)], tbl[i].exp);
            close_cmd(tbl[i].name);
        end

        // Wrong-op word in LD_A is not acknowledged.
        en = 1'b1;
        tick();
        valid = 1'b1;
        instr_op = INSTR_INFO;
        instr_info = 16'h0005;
        tick();
        check("wrongop ack",   VEC_W'(ack), VEC_W'(0));
        check("wrongop state", VEC_W'(dut.state_q), VEC_W'(ST_LD_A));
        instr_op = INSTR_LD;
        instr_info = 16'h0010;
        tick();
        valid = 1'b0;
        check("ld ack",   VEC_W'(ack), VEC_W'(1));
        check("ld state", VEC_W'(dut.state_q), VEC_W'(ST_LD_B));
        tick();
        check("ack pulse", VEC_W'(ack), VEC_W'(0));
        do_reset();

        // count=0 finishes immediately without touching memory.
        setup("cnt0", 16'h0010, 16'h0020, 16'h0030, 0, 2'd1);
        check("cnt0 finish", VEC_W'(finish), VEC_W'(1));
        check("cnt0 req",    VEC_W'(req),    VEC_W'(0));
        tick();
        check("cnt0 req later", VEC_W'(req), VEC_W'(0));
        close_cmd("cnt0");
        check("cnt0 finish drop", VEC_W'(finish), VEC_W'(0));

        // Grant withheld in FETCH_B.
        setup("stall", 16'h0010, 16'h0020, 16'h0038, 1, 2'd0);
        tick();
        grant = 1'b0;
        buf_a0 = mem[16'h0010];
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("stall req %0d", k),  VEC_W'(req),  VEC_W'(1));
            check($sformatf("stall addr %0d", k), VEC_W'(addr), VEC_W'(16'h0020));
            check($sformatf("stall bufa %0d", k), dut.buf_a_q,  buf_a0);
        end
        grant = 1'b1;
        tick();
        check("stall exec state", VEC_W'(dut.state_q), VEC_W'(ST_EXEC));
        check("stall exec req",   VEC_W'(req),         VEC_W'(0));
        wait_finish("stall", n);
        check("stall result", wmem[16'h0038], {32'd44, 32'd33, 32'd22, 32'd11});
        close_cmd("stall");

        // Reset held for two cycles mid-WRITE aborts the command.
        setup("abort", 16'h0010, 16'h0020, 16'h0070, 3, 2'd0);
        n = 0;
        while (!we && n < 20) begin
            tick();
            n++;
        end
        check("abort reached write", VEC_W'(we), VEC_W'(1));
        rst = 1'b1;
        en = 1'b0;
        tick();
        check("abort req",    VEC_W'(req),    VEC_W'(0));
        check("abort busy",   VEC_W'(busy),   VEC_W'(0));
        check("abort finish", VEC_W'(finish), VEC_W'(0));
        check("abort ack",    VEC_W'(ack),    VEC_W'(0));
        tick();
        rst = 1'b0;
        tick();
        check("abort idle", VEC_W'(busy), VEC_W'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
